debug_cmd_sequencer: RTL and testbench
======================================

# debug_cmd_sequencer

Byte-stream command sequencer that lets the debug UART act as a Wishbone master into the management SoC. It parses read and write command frames from the UART receive stream and runs one Wishbone classic cycle per frame. It returns a status byte, plus read data for reads, on the UART transmit stream. It sits between the debug UART byte FIFOs and the debug master port of the Wishbone arbiter.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024, cycles without `wb_ack_i` before a bus cycle is aborted; used only with the timeout feature.

Ports:
- core_clk  in  1  single clock; all state changes on the rising edge.
- core_rstn  in  1  asynchronous, active-low reset.
- rx_data  in  8  received command byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  sequencer accepts a byte this cycle.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART transmitter accepts a byte.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_dat_i  in  32  Wishbone read data.
- wb_sel_o  out  4  byte selects; always 4'hF during a cycle.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  acknowledge.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky error flag, set by a NAK response.

## Operation
- Frame formats. All multi-byte fields are sent MSB first.
  - Write: 0x01, addr[4], data[4].
  - Read: 0x02, addr[4].
- States: IDLE, ADDR, DATA, BUS, RESP.
- IDLE: rx_ready=1. An accepted byte is handled as follows.
  - 0x01 or 0x02: latch the opcode, clear the byte counter, go to ADDR, clear err.
  - Any other value: go to RESP with NAK 0xEE and set err.
- ADDR: rx_ready=1. Shift 4 bytes into the address register using a 2-bit counter.
  - After the 4th byte, a write goes to DATA and a read goes to BUS.
- DATA: rx_ready=1. Shift 4 bytes into wb_dat_o, then go to BUS.
- BUS: rx_ready=0. Drive cyc=stb=1, sel=4'hF, and we=1 for writes.
  - On wb_ack_i: drop cyc/stb on the next edge, capture wb_dat_i for reads, go to RESP.
- RESP: tx_valid=1.
  - Byte 0 is ACK 0xAC or NAK 0xEE.
  - A successful read appends 4 read-data bytes, MSB first.
  - tx_data advances only on tx_valid&tx_ready.
  - After the last byte, go to IDLE.
- Handshake rules:
  - A byte transfers only on the cycle where valid and ready are both high.
  - tx_data stays stable while tx_valid=1 and tx_ready=0.
  - The gap between received bytes is unbounded; there is no inter-byte timeout.

## Timing
- Reset values: state=IDLE, so rx_ready=1. Every other output is 0: tx_valid, tx_data, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, busy, err.
- Last frame byte accepted at edge N: cyc/stb are high from edge N+1.
- Ack sampled at edge M: cyc/stb are low and tx_valid=1 (0xAC) from edge M+1.
- One byte is consumed per cycle at most.
- An ack that arrives while stb=0 is ignored.
- Reset asserted mid-frame or mid-cycle: cyc/stb drop immediately (asynchronously), the partial frame is discarded, and the sequencer returns to IDLE.
- tx_ready held low: RESP is held indefinitely and no new command is accepted.

## Configuration
- DEBUG_SEQ_TIMEOUT_EN defined:
  - A counter runs in BUS. Reaching TIMEOUT_CYCLES without ack drops cyc/stb on the next edge, sends the single byte 0xEE, and sets err.
  - If ack and timeout occur in the same cycle, the ack wins.
- Not defined: BUS waits for ack forever. The counter logic and TIMEOUT_CYCLES are unused.

## Structure
- Shared package debug_seq_pkg holds:
  - The state enum.
  - The opcode constants OP_WRITE=8'h01 and OP_READ=8'h02.
  - The response constants RSP_ACK=8'hAC and RSP_NAK=8'hEE.
- One sub-module: debug_seq_wdt, a loadable down-counter with expired flag, width $clog2(TIMEOUT_CYCLES+1). It is instantiated only under DEBUG_SEQ_TIMEOUT_EN.

## Test plan
- Write frame 01 30 00 00 00 DE AD BE EF, ack after 3 cycles -> one cycle with adr=0x30000000, dat_o=0xDEADBEEF, we=1, sel=F; tx emits 0xAC; err=0.
- Read frame 02 26 00 00 0C, ack with dat_i=0x12345678 -> tx emits AC 12 34 56 78 in order; busy falls after the last byte.
- Unknown opcode 0x7F -> tx emits 0xEE, err=1, no Wishbone cycle. A following valid write clears err.
- tx_ready held low for 50 cycles during the read response -> tx_data stays 0xAC and rx_ready=0 throughout. Release -> the remaining bytes follow.
- With DEBUG_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack -> cyc drops after 16 BUS cycles, tx emits 0xEE, err=1.
- core_rstn pulsed low after the third address byte -> all outputs return to 0 at once and rx_ready=1. A fresh full frame then completes normally.

Source files
------------

// File: rtl/debug_seq_pkg.sv
// Shared definitions for the debug UART command sequencer: FSM state codes,
// frame opcodes and response bytes.
package debug_seq_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_BUS  = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] RSP_ACK  = 8'hAC;
    localparam logic [7:0] RSP_NAK  = 8'hEE;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/debug_seq_wdt.sv
// Loadable down-counter that flags expiry when it reaches zero; used as the
// Wishbone cycle watchdog of the debug command sequencer.
module debug_seq_wdt #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             dec,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Saturates at zero so a held-off bus cycle keeps reporting expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/debug_cmd_sequencer.sv
// Debug UART byte stream to Wishbone master: parses read/write frames, runs one
// classic bus cycle per frame and returns ACK/NAK plus read data. Optional bus
// timeout is enabled with DEBUG_SEQ_TIMEOUT_EN.
module debug_cmd_sequencer
    import debug_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        core_clk,
    input  logic        core_rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        busy,
    output logic        err
);

    state_t      state;
    logic        is_write;
    logic [1:0]  byte_cnt;
    logic [31:0] rdata;
    logic [2:0]  tx_left;
    logic        rx_fire;
    logic        tx_fire;
    logic        ack_take;
    logic        timeout_hit;
    logic        frame_done;
    logic        bus_end;

    // Byte streams: a byte moves only on a cycle where valid and ready are both
    // high; tx_valid/tx_data are registered and hold until tx_ready accepts.
    assign rx_ready = (state == ST_IDLE) || (state == ST_ADDR) || (state == ST_DATA);
    assign busy     = (state != ST_IDLE);
    assign rx_fire  = rx_valid & rx_ready;
    assign tx_fire  = tx_valid & tx_ready;
    assign ack_take = wb_ack_i & wb_stb_o;

    assign frame_done = rx_fire && (byte_cnt == 2'd3) &&
                        (((state == ST_ADDR) && !is_write) || (state == ST_DATA));
    assign bus_end    = (state == ST_BUS) && (ack_take || timeout_hit);

`ifdef DEBUG_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic tmo_expired;

    // Reloaded outside BUS; expires on the last permitted BUS cycle.
    debug_seq_wdt #(
        .WIDTH(TMO_W)
    ) u_wdt (
        .clk    (core_clk),
        .rst_n  (core_rstn),
        .load   (state != ST_BUS),
        .value  (TMO_W'(TIMEOUT_CYCLES - 1)),
        .dec    (state == ST_BUS),
        .expired(tmo_expired)
    );

    assign timeout_hit = (state == ST_BUS) & tmo_expired;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state    <= ST_IDLE;
            is_write <= 1'b0;
            byte_cnt <= 2'd0;
            wb_adr_o <= 32'h0;
            wb_dat_o <= 32'h0;
            rdata    <= 32'h0;
            tx_left  <= 3'd0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_fire) begin
                        if (is_opcode(rx_data)) begin
                            is_write <= (rx_data == OP_WRITE);
                            byte_cnt <= 2'd0;
                            err      <= 1'b0;
                            state    <= ST_ADDR;
                        end else begin
                            err      <= 1'b1;
                            tx_valid <= 1'b1;
                            tx_data  <= RSP_NAK;
                            tx_left  <= 3'd0;
                            state    <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_fire) begin
                        wb_adr_o <= {wb_adr_o[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= is_write ? ST_DATA : ST_BUS;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_fire) begin
                        wb_dat_o <= {wb_dat_o[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    // Ack has priority over a timeout landing in the same cycle.
                    if (ack_take) begin
                        tx_valid <= 1'b1;
                        tx_data  <= RSP_ACK;
                        state    <= ST_RESP;
                        if (!is_write) begin
                            rdata   <= wb_dat_i;
                            tx_left <= 3'd4;
                        end else begin
                            tx_left <= 3'd0;
                        end
                    end else if (timeout_hit) begin
                        err      <= 1'b1;
                        tx_valid <= 1'b1;
                        tx_data  <= RSP_NAK;
                        tx_left  <= 3'd0;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (tx_fire) begin
                        if (tx_left == 3'd0) begin
                            tx_valid <= 1'b0;
                            tx_data  <= 8'h00;
                            state    <= ST_IDLE;
                        end else begin
                            tx_data <= rdata[31:24];
                            rdata   <= {rdata[23:0], 8'h00};
                            tx_left <= tx_left - 3'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus controls are registered so cyc/stb/we/sel change together.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_sel_o <= 4'h0;
            wb_we_o  <= 1'b0;
        end else if (frame_done) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_sel_o <= 4'hF;
            wb_we_o  <= is_write;
        end else if (bus_end) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_sel_o <= 4'h0;
            wb_we_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Self-checking bench for debug_cmd_sequencer: directed frames, stalls, resets
// and randomized traffic against a frame-level reference model.
module tb_debug_cmd_sequencer;

    logic        core_clk;
    logic        core_rstn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        busy;
    logic        err;

    debug_cmd_sequencer #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .core_clk (core_clk),
        .core_rstn(core_rstn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i),
        .busy     (busy),
        .err      (err)
    );

    // ---------------- clock / reset ----------------
    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    logic [64:0] exp_bus_q[$];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] slave_mem[logic [31:0]];
    bit          model_err;
    int          tx_mode;
    int          ack_mode;
    int          ack_delay_fixed;
    bit          spurious_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] slave_word(input logic [31:0] a);
        if (slave_mem.exists(a)) return slave_mem[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // ---------------- tx monitor ----------------
    bit         tx_stalled = 0;
    logic [7:0] tx_last;

    always @(negedge core_clk) begin
        case (tx_mode)
            0:       tx_ready = ($urandom_range(0, 3) != 0);
            1:       tx_ready = 1'b0;
            default: tx_ready = 1'b1;
        endcase
        #1;
        if (core_rstn && tx_valid) begin
            if (tx_stalled) check("tx_stable", {24'h0, tx_data}, {24'h0, tx_last});
            if (tx_ready) begin
                if (exp_q.size() == 0) check("tx_unexpected", {24'h0, tx_data}, 32'h100);
                else check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                tx_stalled = 0;
            end else begin
                tx_stalled = 1;
                tx_last    = tx_data;
            end
        end else begin
            tx_stalled = 0;
        end
    end

    // ---------------- Wishbone slave ----------------
    int          wait_cnt = 0;
    int          ack_delay = 0;
    bit          acked_prev = 0;
    logic [64:0] bus_exp;

    always @(negedge core_clk) begin
        if (acked_prev) begin
            acked_prev = 0;
            check("ack_cyc_drop", {31'h0, wb_cyc_o}, 32'h0);
            check("ack_tx_valid", {31'h0, tx_valid}, 32'h1);
            check("ack_tx_first", {24'h0, tx_data}, 32'hAC);
        end
        wb_ack_i = 1'b0;
        wb_dat_i = $urandom;
        if (wb_cyc_o && wb_stb_o && ack_mode != 2) begin
            if (wait_cnt >= ack_delay) begin
                wb_ack_i   = 1'b1;
                acked_prev = 1;
                check("bus_sel", {28'h0, wb_sel_o}, 32'hF);
                if (exp_bus_q.size() == 0) begin
                    check("bus_unexpected", {31'h0, wb_cyc_o}, 32'h0);
                end else begin
                    bus_exp = exp_bus_q.pop_front();
                    check("bus_we", {31'h0, wb_we_o}, {31'h0, bus_exp[64]});
                    check("bus_adr", wb_adr_o, bus_exp[63:32]);
                    if (bus_exp[64]) check("bus_dat_o", wb_dat_o, bus_exp[31:0]);
                end
                if (wb_we_o) slave_mem[wb_adr_o] = wb_dat_o;
                else wb_dat_i = slave_word(wb_adr_o);
            end else begin
                wait_cnt++;
            end
        end else if (!wb_cyc_o) begin
            wait_cnt  = 0;
            ack_delay = (ack_mode == 1) ? ack_delay_fixed : $urandom_range(0, 4);
            if (spurious_en && $urandom_range(0, 5) == 0) wb_ack_i = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        int n;
        repeat ($urandom_range(0, 2)) @(negedge core_clk);
        @(negedge core_clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 2000) begin
            @(negedge core_clk);
            n++;
        end
        check("rx_ready", {31'h0, rx_ready}, 32'h1);
        @(posedge core_clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        model_mem[a] = d;
        exp_bus_q.push_back({1'b1, a, d});
        exp_q.push_back(8'hAC);
        model_err = 0;
        send_byte(8'h01);
        check("err_cleared", {31'h0, err}, 32'h0);
        send_word(a);
        send_word(d);
        check("cyc_after_frame", {31'h0, wb_cyc_o}, 32'h1);
    endtask

    task automatic do_read(input logic [31:0] a);
        logic [31:0] d;
        d = model_word(a);
        exp_bus_q.push_back({1'b0, a, 32'h0});
        exp_q.push_back(8'hAC);
        for (int i = 3; i >= 0; i--) exp_q.push_back(d[i*8 +: 8]);
        model_err = 0;
        send_byte(8'h02);
        send_word(a);
        check("cyc_after_frame", {31'h0, wb_cyc_o}, 32'h1);
    endtask

    task automatic do_bad(input logic [7:0] b);
        exp_q.push_back(8'hEE);
        model_err = 1;
        send_byte(b);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge core_clk);
            #2;
            if (!busy && exp_q.size() == 0) break;
        end
        check("idle_busy", {31'h0, busy}, 32'h0);
        check("idle_tx_left", 32'(exp_q.size()), 32'h0);
        check("err_flag", {31'h0, err}, {31'h0, model_err});
    endtask

    task automatic check_reset_outputs();
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
        check("rst_stb", {31'h0, wb_stb_o}, 32'h0);
        check("rst_we", {31'h0, wb_we_o}, 32'h0);
        check("rst_sel", {28'h0, wb_sel_o}, 32'h0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
    endtask

    task automatic pulse_reset();
        #3;
        core_rstn = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        exp_bus_q.delete();
        model_err = 0;
        @(negedge core_clk);
        core_rstn = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0]  b;
        logic [31:0] a;
        int          r;
        int          cyc_cycles;

        core_rstn       = 1'b0;
        rx_data         = 8'h00;
        rx_valid        = 1'b0;
        tx_ready        = 1'b0;
        wb_dat_i        = 32'h0;
        wb_ack_i        = 1'b0;
        tx_mode         = 2;
        ack_mode        = 0;
        ack_delay_fixed = 0;
        spurious_en     = 0;
        model_err       = 0;

        repeat (3) @(negedge core_clk);
        check_reset_outputs();
        core_rstn = 1'b1;
        @(negedge core_clk);
        check("post_rst_rx_ready", {31'h0, rx_ready}, 32'h1);

        // Write frame with an ack three cycles into the bus cycle.
        ack_mode = 1;
        ack_delay_fixed = 3;
        do_write(32'h3000_0000, 32'hDEAD_BEEF);
        wait_idle();

        // Read frame with known slave data.
        ack_mode = 0;
        model_mem[32'h2600_000C] = 32'h1234_5678;
        slave_mem[32'h2600_000C] = 32'h1234_5678;
        do_read(32'h2600_000C);
        wait_idle();

        // Unknown opcode, then a write that clears err.
        do_bad(8'h7F);
        wait_idle();
        do_write(32'h3000_0004, 32'h0BAD_F00D);
        wait_idle();

        // Transmitter stalled during a read response.
        tx_mode = 1;
        do_read(32'h2600_000C);
        for (int i = 0; i < 100; i++) begin
            @(negedge core_clk);
            #2;
            if (tx_valid) break;
        end
        check("stall_tx_valid", {31'h0, tx_valid}, 32'h1);
        for (int i = 0; i < 50; i++) begin
            @(negedge core_clk);
            #2;
            check("stall_tx_data", {24'h0, tx_data}, 32'hAC);
            check("stall_rx_ready", {31'h0, rx_ready}, 32'h0);
        end
        tx_mode = 0;
        wait_idle();

        // Reset after the third address byte.
        tx_mode = 2;
        send_byte(8'h02);
        send_byte(8'h26);
        send_byte(8'h00);
        send_byte(8'h00);
        pulse_reset();
        do_write(32'h3000_0008, 32'hCAFE_0001);
        wait_idle();

        // Reset while a bus cycle is outstanding.
        ack_mode = 2;
        send_byte(8'h02);
        send_word(32'h1122_3344);
        repeat (3) @(negedge core_clk);
        check("bus_pre_reset_cyc", {31'h0, wb_cyc_o}, 32'h1);
        pulse_reset();
        ack_mode = 0;
        do_read(32'h3000_0008);
        wait_idle();

`ifdef DEBUG_SEQ_TIMEOUT_EN
        // No ack: the cycle is abandoned after 16 bus cycles.
        ack_mode = 2;
        exp_q.push_back(8'hEE);
        model_err = 1;
        send_byte(8'h02);
        send_word(32'h4000_0000);
        cyc_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge core_clk);
            #2;
            if (wb_cyc_o) cyc_cycles++;
            else break;
        end
        check("timeout_cycles", 32'(cyc_cycles), 32'd16);
        wait_idle();
        ack_mode = 0;
`else
        cyc_cycles = 0;
`endif

        // Randomized traffic.
        tx_mode     = 0;
        spurious_en = 1;
        for (int f = 0; f < 40; f++) begin
            r = $urandom_range(0, 9);
            a = 32'h3000_0000 + 32'($urandom_range(0, 7)) * 4;
            if ($urandom_range(0, 3) == 0) a = $urandom;
            if (r < 4) begin
                do_write(a, $urandom);
            end else if (r < 8) begin
                do_read(a);
            end else begin
                b = 8'($urandom);
                while (b == 8'h01 || b == 8'h02) b = 8'($urandom);
                do_bad(b);
            end
            wait_idle();
        end
        spurious_en = 0;
        repeat (4) @(negedge core_clk);
        check("bus_all_done", 32'(exp_bus_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
